// File: rtl/interrupt_scheduler.sv
// Priority interrupt scheduler: edge-detected sources, maskable pending register, one-at-a-time dispatch.
// Defining INTSCHED_ACK_TIMEOUT_EN compiles in an ack watchdog that requeues an unacknowledged interrupt.
module interrupt_scheduler #(
   parameter int NUM_SRC = 8,
   parameter int TIMEOUT = 1024
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] i_int,
   input  logic               i_mask_we,
   input  logic [NUM_SRC-1:0] i_mask_data,
   input  logic               i_ack,
   output logic               o_int,
   output logic [31:0]        o_int_id,
   output logic [NUM_SRC-1:0] o_pending,
   output logic               o_busy,
   output logic               o_timeout
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] RAISE    = 2'd1;
   localparam logic [1:0] WAIT_ACK = 2'd2;

   logic [1:0]         r_state;
   logic [NUM_SRC-1:0] r_pending;
   logic [NUM_SRC-1:0] r_mask;
   logic [NUM_SRC-1:0] r_intPrev;
   logic               r_int;
   logic [31:0]        r_intId;

   logic [NUM_SRC-1:0] w_event;
   logic [NUM_SRC-1:0] w_eligible;
   logic [NUM_SRC-1:0] w_winnerHot;
   logic [NUM_SRC-1:0] w_clear;
   logic [NUM_SRC-1:0] w_requeue;
   logic [31:0]        w_winnerId;
   logic               w_dispatch;
   logic               w_expire;

   assign w_event    = i_int & ~r_intPrev;
   assign w_eligible = r_pending & ~r_mask;
   assign w_dispatch = (r_state == IDLE) && (|w_eligible);
   assign w_clear    = w_dispatch ? w_winnerHot : '0;

   // Scan from the top down so the lowest set index is the one left standing.
   always_comb begin
      w_winnerId  = 32'd0;
      w_winnerHot = '0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         if (w_eligible[k]) begin
            w_winnerId     = 32'(k + 1);
            w_winnerHot    = '0;
            w_winnerHot[k] = 1'b1;
         end
      end
   end

`ifdef INTSCHED_ACK_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   logic [CNT_W-1:0]   r_toCount;
   logic               r_timeout;
   logic [NUM_SRC-1:0] w_inServiceHot;

   always_comb begin
      w_inServiceHot = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         w_inServiceHot[k] = (r_intId == 32'(k + 1));
      end
   end

   // An ack on the expiry cycle takes precedence, so expiry requires i_ack low.
   assign w_expire  = (r_state == WAIT_ACK) && !i_ack && (r_toCount == CNT_W'(TIMEOUT - 1));
   assign w_requeue = w_expire ? w_inServiceHot : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_toCount <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_expire;
         if ((r_state == WAIT_ACK) && !i_ack && !w_expire) begin
            r_toCount <= r_toCount + 1'b1;
         end else begin
            r_toCount <= '0;
         end
      end
   end

   assign o_timeout = r_timeout;
`else
   logic w_unusedTimeout;

   assign w_unusedTimeout = (TIMEOUT > 0);
   assign w_expire        = 1'b0;
   assign w_requeue       = '0;
   assign o_timeout       = 1'b0;
`endif

   // A new event on the bit being dispatched survives the clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pending <= '0;
         r_intPrev <= '0;
      end else begin
         r_intPrev <= i_int;
         r_pending <= (r_pending & ~w_clear) | w_event | w_requeue;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mask <= '0;
      end else if (i_mask_we) begin
         r_mask <= i_mask_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_int   <= 1'b0;
         r_intId <= 32'd0;
      end else begin
         r_int <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_dispatch) begin
                  r_intId <= w_winnerId;
                  r_int   <= 1'b1;
                  r_state <= RAISE;
               end
            end
            RAISE: begin
               r_state <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (i_ack || w_expire) begin
                  r_intId <= 32'd0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign o_int     = r_int;
   assign o_int_id  = r_intId;
   assign o_pending = r_pending;
   assign o_busy    = (r_state != IDLE);

endmodule
